pipe_ctrl_hz: RTL and testbench

- Parametrised, hazard-aware pipelined control path for the 5-stage MIPS-subset CPU.
- Decodes op/funct in Decode, then carries the control word through D→E, E→M and M→W pipeline registers.
- Resolves branch/jump in Memory and detects load-use hazards.
- Drives stall/flush to the datapath and inserts bubbles internally.

---
 rtl/pipe_ctrl_hz_if.sv | 43 ++++
 rtl/pipe_ctrl_hz.sv | 173 +++++++++++++++++
 tb/tb_pipe_ctrl_hz.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_hz_if.sv
// Control-path bundle between the 5-stage datapath and pipe_ctrl_hz.
// The datapath side (master) supplies instruction fields and the zero flag;
// the controller side (slave) returns pipelined control and hazard signals.
interface pipe_ctrl_hz_if #(
    parameter int ALUC_W = 3,
    parameter int REG_AW = 5
);
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic [REG_AW-1:0] rtE;
    logic              zeroM;

    logic              regdstE;
    logic              alusrcE;
    logic [ALUC_W-1:0] alucontrolE;
    logic              regwriteE;
    logic              memtoregE;
    logic              regwriteM;
    logic              memwriteM;
    logic              pcsrcM;
    logic              jumpM;
    logic              regwriteW;
    logic              memtoregW;
    logic              stallF;
    logic              stallD;
    logic              flushD;

    modport master (
        output op, funct, rsD, rtD, rtE, zeroM,
        input  regdstE, alusrcE, alucontrolE, regwriteE, memtoregE,
               regwriteM, memwriteM, pcsrcM, jumpM,
               regwriteW, memtoregW, stallF, stallD, flushD
    );

    modport slave (
        input  op, funct, rsD, rtD, rtE, zeroM,
        output regdstE, alusrcE, alucontrolE, regwriteE, memtoregE,
               regwriteM, memwriteM, pcsrcM, jumpM,
               regwriteW, memtoregW, stallF, stallD, flushD
    );
endinterface

// File: rtl/pipe_ctrl_hz.sv
// Hazard-aware pipelined control path for the 5-stage MIPS-subset CPU.
// Decode is combinational; the control word then rides D->E, E->M and M->W
// registers. Branches/jumps resolve in Memory; load-use hazards stall F/D
// and bubble E. A redirect always wins over a load-use stall.
// Optional: define PIPE_CTRL_HZ_BNE_EN to add bne (opcode 000101).
module pipe_ctrl_hz #(
    parameter int ALUC_W = 3,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    pipe_ctrl_hz_if.slave bus
);
    // decoded (Decode stage) control
    logic              regwrite_d, regdst_d, alusrc_d, branch_d;
    logic              memwrite_d, memtoreg_d, jump_d;
    logic [1:0]        aluop_d;
    logic [2:0]        alu_code_d;
    logic [ALUC_W-1:0] alucontrol_d;

    // Execute stage
    logic              regwrite_e, regdst_e, alusrc_e, branch_e;
    logic              memwrite_e, memtoreg_e, jump_e;
    logic [ALUC_W-1:0] alucontrol_e;

    // Memory stage
    logic              regwrite_m, memtoreg_m, memwrite_m, branch_m, jump_m;

    // Writeback stage
    logic              regwrite_w, memtoreg_w;

    // hazard terms
    logic              pcsrc_m, redirect, lwstall, flush_e, flush_m;

`ifdef PIPE_CTRL_HZ_BNE_EN
    logic              bne_d, bne_e, bne_m;
`endif

    // Main decoder: opcode to control word, unknown opcodes become a NOP
    always_comb begin
        regwrite_d = 1'b0;
        regdst_d   = 1'b0;
        alusrc_d   = 1'b0;
        branch_d   = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        jump_d     = 1'b0;
        aluop_d    = 2'b00;
`ifdef PIPE_CTRL_HZ_BNE_EN
        bne_d      = 1'b0;
`endif
        case (bus.op)
            6'b000000: begin regwrite_d = 1'b1; regdst_d = 1'b1; aluop_d = 2'b10; end
            6'b100011: begin regwrite_d = 1'b1; alusrc_d = 1'b1; memtoreg_d = 1'b1; end
            6'b101011: begin alusrc_d = 1'b1; memwrite_d = 1'b1; end
            6'b000100: begin branch_d = 1'b1; aluop_d = 2'b01; end
            6'b001000: begin regwrite_d = 1'b1; alusrc_d = 1'b1; end
            6'b000010: begin jump_d = 1'b1; end
`ifdef PIPE_CTRL_HZ_BNE_EN
            6'b000101: begin branch_d = 1'b1; bne_d = 1'b1; aluop_d = 2'b01; end
`endif
            default: ;
        endcase
    end

    // ALU decoder: aluop plus funct to the 3-bit ALU code, zero-extended
    always_comb begin
        alu_code_d = 3'b010;
        case (aluop_d)
            2'b00: alu_code_d = 3'b010;
            2'b01: alu_code_d = 3'b110;
            default: begin
                case (bus.funct)
                    6'b100000: alu_code_d = 3'b010;
                    6'b100010: alu_code_d = 3'b110;
                    6'b100100: alu_code_d = 3'b000;
                    6'b100101: alu_code_d = 3'b001;
                    6'b101010: alu_code_d = 3'b111;
                    default:   alu_code_d = 3'b000;
                endcase
            end
        endcase
        alucontrol_d = ALUC_W'(alu_code_d);
    end

    // Branch resolution and hazard detection on registered stage state
`ifdef PIPE_CTRL_HZ_BNE_EN
    assign pcsrc_m  = branch_m & (bus.zeroM ^ bne_m);
`else
    assign pcsrc_m  = branch_m & bus.zeroM;
`endif
    assign redirect = pcsrc_m | jump_m;
    assign lwstall  = memtoreg_e & regwrite_e & (bus.rtE != '0) &
                      ((bus.rtE == bus.rsD) | (bus.rtE == bus.rtD));
    assign flush_e  = lwstall | redirect;
    assign flush_m  = redirect;

    // D->E register: a bubble replaces the word on stall or redirect
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            regwrite_e   <= 1'b0;
            regdst_e     <= 1'b0;
            alusrc_e     <= 1'b0;
            branch_e     <= 1'b0;
            memwrite_e   <= 1'b0;
            memtoreg_e   <= 1'b0;
            jump_e       <= 1'b0;
            alucontrol_e <= '0;
        end else begin
            regwrite_e   <= regwrite_d;
            regdst_e     <= regdst_d;
            alusrc_e     <= alusrc_d;
            branch_e     <= branch_d;
            memwrite_e   <= memwrite_d;
            memtoreg_e   <= memtoreg_d;
            jump_e       <= jump_d;
            alucontrol_e <= alucontrol_d;
        end
    end

    // E->M register: the wrong-path instruction in E is dropped on redirect
    always_ff @(posedge clk) begin
        if (reset || flush_m) begin
            regwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
            memwrite_m <= 1'b0;
            branch_m   <= 1'b0;
            jump_m     <= 1'b0;
        end else begin
            regwrite_m <= regwrite_e;
            memtoreg_m <= memtoreg_e;
            memwrite_m <= memwrite_e;
            branch_m   <= branch_e;
            jump_m     <= jump_e;
        end
    end

    // M->W register: the instruction in M always completes, so only reset clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
        end else begin
            regwrite_w <= regwrite_m;
            memtoreg_w <= memtoreg_m;
        end
    end

`ifdef PIPE_CTRL_HZ_BNE_EN
    // bne flag follows branch through E and M with identical flushing
    always_ff @(posedge clk) begin
        if (reset || flush_e) bne_e <= 1'b0;
        else                  bne_e <= bne_d;
        if (reset || flush_m) bne_m <= 1'b0;
        else                  bne_m <= bne_e;
    end
`endif

    assign bus.regdstE     = regdst_e;
    assign bus.alusrcE     = alusrc_e;
    assign bus.alucontrolE = alucontrol_e;
    assign bus.regwriteE   = regwrite_e;
    assign bus.memtoregE   = memtoreg_e;
    assign bus.regwriteM   = regwrite_m;
    assign bus.memwriteM   = memwrite_m;
    assign bus.pcsrcM      = pcsrc_m;
    assign bus.jumpM       = jump_m;
    assign bus.regwriteW   = regwrite_w;
    assign bus.memtoregW   = memtoreg_w;
    assign bus.stallF      = lwstall & ~redirect;
    assign bus.stallD      = lwstall & ~redirect;
    assign bus.flushD      = redirect;
endmodule

// File: tb/tb_pipe_ctrl_hz.sv
// Self-checking bench for pipe_ctrl_hz: directed sequences followed by
// random instruction streams, compared against an instruction-level model
// that tracks which decoded instruction occupies each pipeline stage.
module tb_pipe_ctrl_hz;
    localparam int ALUC_W = 3;
    localparam int REG_AW = 5;

    // One decoded instruction as seen by the pipeline
    typedef struct {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic       bne;
        logic [2:0] aluc;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // stage 0 = Execute, 1 = Memory, 2 = Writeback
    ctl_t stage [3];
    ctl_t nxt   [3];

    pipe_ctrl_hz_if #(.ALUC_W(ALUC_W), .REG_AW(REG_AW)) bus ();

    pipe_ctrl_hz #(.ALUC_W(ALUC_W), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // free-running clock
    always #5 clk = ~clk;

    function automatic ctl_t bubble();
        ctl_t c;
        c = '{default: '0};
        return c;
    endfunction

    // Instruction meaning straight from the decode and ALU tables
    function automatic ctl_t decode(input logic [5:0] o, input logic [5:0] f);
        ctl_t c;
        c = bubble();
        c.aluc = 3'b010;
        case (o)
            6'b000000: begin
                c.regwrite = 1; c.regdst = 1;
                case (f)
                    6'b100000: c.aluc = 3'b010;
                    6'b100010: c.aluc = 3'b110;
                    6'b100100: c.aluc = 3'b000;
                    6'b100101: c.aluc = 3'b001;
                    6'b101010: c.aluc = 3'b111;
                    default:   c.aluc = 3'b000;
                endcase
            end
            6'b100011: begin c.regwrite = 1; c.alusrc = 1; c.memtoreg = 1; end
            6'b101011: begin c.alusrc = 1; c.memwrite = 1; end
            6'b000100: begin c.branch = 1; c.aluc = 3'b110; end
            6'b001000: begin c.regwrite = 1; c.alusrc = 1; end
            6'b000010: c.jump = 1;
`ifdef PIPE_CTRL_HZ_BNE_EN
            6'b000101: begin c.branch = 1; c.bne = 1; c.aluc = 3'b110; end
`endif
            default: ;
        endcase
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Drive one cycle of inputs, optionally check outputs, advance the model
    task automatic applyStimulus(input logic rst, input logic [5:0] o, input logic [5:0] f,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rte, input logic z, input bit chk);
        logic lw, pc, redir;
        reset     = rst;
        bus.op    = o;
        bus.funct = f;
        bus.rsD   = rs;
        bus.rtD   = rt;
        bus.rtE   = rte;
        bus.zeroM = z;
        @(negedge clk);
        lw    = stage[0].memtoreg && stage[0].regwrite && rte != 0 && (rte == rs || rte == rt);
        pc    = stage[1].branch && (z != stage[1].bne);
        redir = pc || stage[1].jump;
        if (chk) begin
            checkOutput("regdstE",     8'(bus.regdstE),     8'(stage[0].regdst));
            checkOutput("alusrcE",     8'(bus.alusrcE),     8'(stage[0].alusrc));
            checkOutput("alucontrolE", 8'(bus.alucontrolE), 8'(stage[0].aluc));
            checkOutput("regwriteE",   8'(bus.regwriteE),   8'(stage[0].regwrite));
            checkOutput("memtoregE",   8'(bus.memtoregE),   8'(stage[0].memtoreg));
            checkOutput("regwriteM",   8'(bus.regwriteM),   8'(stage[1].regwrite));
            checkOutput("memwriteM",   8'(bus.memwriteM),   8'(stage[1].memwrite));
            checkOutput("pcsrcM",      8'(bus.pcsrcM),      8'(pc));
            checkOutput("jumpM",       8'(bus.jumpM),       8'(stage[1].jump));
            checkOutput("regwriteW",   8'(bus.regwriteW),   8'(stage[2].regwrite));
            checkOutput("memtoregW",   8'(bus.memtoregW),   8'(stage[2].memtoreg));
            checkOutput("stallF",      8'(bus.stallF),      8'(lw && !redir));
            checkOutput("stallD",      8'(bus.stallD),      8'(lw && !redir));
            checkOutput("flushD",      8'(bus.flushD),      8'(redir));
        end
        if (rst) begin
            nxt[0] = bubble(); nxt[1] = bubble(); nxt[2] = bubble();
        end else begin
            nxt[2] = stage[1];
            nxt[1] = redir ? bubble() : stage[0];
            nxt[0] = (lw || redir) ? bubble() : decode(o, f);
        end
        @(posedge clk);
        #1;
        stage = nxt;
    endtask

    localparam logic [5:0] OPS [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                       6'b001000, 6'b000010, 6'b000101, 6'b111111};
    localparam logic [5:0] FNS [6] = '{6'b100000, 6'b100010, 6'b100100,
                                       6'b100101, 6'b101010, 6'b111111};

    initial begin
        logic [5:0] o, f;
        stage[0] = bubble(); stage[1] = bubble(); stage[2] = bubble();
        @(posedge clk);
        #1;

        // reset held two cycles with lw presented, then lw flows through
        applyStimulus(1, 6'b100011, 0, 1, 2, 0, 0, 0);
        applyStimulus(1, 6'b100011, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b100011, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b000000, 6'b101010, 3, 4, 0, 0, 1);
        applyStimulus(0, 6'b000000, 6'b111111, 3, 4, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);

        // load-use: lw rt=5 then dependent add, held in D during the stall
        applyStimulus(0, 6'b100011, 0, 1, 5, 0, 0, 1);
        applyStimulus(0, 6'b000000, 6'b100000, 5, 7, 5, 0, 1);
        applyStimulus(0, 6'b000000, 6'b100000, 5, 7, 5, 0, 1);
        applyStimulus(0, 6'b000000, 6'b100000, 1, 2, 0, 0, 1);
        // same pattern with rt=0: never a stall
        applyStimulus(0, 6'b100011, 0, 1, 0, 0, 0, 1);
        applyStimulus(0, 6'b000000, 6'b100000, 0, 0, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);

        // beq taken, then not taken
        applyStimulus(0, 6'b000100, 0, 1, 2, 0, 1, 1);
        applyStimulus(0, 6'b101011, 0, 1, 2, 0, 1, 1);
        applyStimulus(0, 6'b001000, 0, 1, 2, 0, 1, 1);
        applyStimulus(0, 6'b000100, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b101011, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b001000, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);

        // jump in M coinciding with a load-use hazard
        applyStimulus(0, 6'b000010, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b100011, 0, 1, 6, 0, 0, 1);
        applyStimulus(0, 6'b000000, 6'b100000, 6, 1, 6, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);

        // bne with zero=0 then zero=1
        applyStimulus(0, 6'b000101, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 6'b000101, 0, 1, 2, 0, 1, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 1, 1);

        // mid-stream reset with stores and loads in flight
        applyStimulus(0, 6'b101011, 0, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b100011, 0, 1, 2, 0, 0, 1);
        applyStimulus(1, 6'b000000, 6'b100000, 1, 2, 0, 0, 1);
        applyStimulus(0, 6'b111111, 0, 0, 0, 0, 0, 1);

        // random instruction streams with small register numbers to provoke hazards
        for (int i = 0; i < 600; i++) begin
            o = OPS[$urandom_range(0, 7)];
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 5)];
            applyStimulus(($urandom_range(0, 49) == 0), o, f,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
